sar_bit_sequencer: RTL and testbench

//  Successive-approximation control FSM for the ADC datapath. Drives the bit-index down-counter
//  (load-low, decrements every clk, holds at 0) and consumes its count value as the current SAR bit index.

---
 rtl/sar_bit_sequencer_pkg.sv | 16 +
 rtl/sar_bit_sequencer.sv | 153 +++++++++++++++
 tb/tb_sar_bit_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_bit_sequencer_pkg.sv
// Shared definitions for the SAR bit sequencer: FSM state encoding
// and the bit-index width helper used to size the down-counter link.
package sar_bit_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } sar_state_t;

   // Width of a bit index able to address 0..nbits-1 (never below 1).
   function automatic int idx_width(input int nbits);
      return (nbits > 1) ? $clog2(nbits) : 1;
   endfunction

endpackage

// File: rtl/sar_bit_sequencer.sv
// Successive-approximation control FSM: steps an external bit-index
// down-counter, builds the trial DAC code from the comparator one bit
// per cycle and hands the final code downstream on valid/ready.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, abort         conversion request (IDLE only) / cancel (CONVERT)
//   cmp_in               comparator, 1 = Vin >= DAC(dac_code)
//   cnt_val              down-counter value = current bit index
//   cnt_load_n           counter reset_n, 0 holds counter at cnt_from
//   cnt_from             constant NBITS-1
//   dac_code             registered trial code
//   busy                 high while converting
//   result/result_valid  final code, held until result_ready
//   fault                sticky out-of-range index flag
module sar_bit_sequencer
   import sar_bit_sequencer_pkg::*;
#(
   parameter int NBITS = 8,
   parameter int IDX_W = idx_width(NBITS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_in,
   input  logic [IDX_W-1:0] cnt_val,
   output logic             cnt_load_n,
   output logic [IDX_W-1:0] cnt_from,
   output logic [NBITS-1:0] dac_code,
   output logic             busy,
   output logic [NBITS-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             fault
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
   localparam logic [NBITS-1:0] MSB_CODE = NBITS'(1) << (NBITS - 1);

   sar_state_t       state;
   sar_state_t       state_nxt;
   logic [NBITS-1:0] dac_nxt;
   logic [NBITS-1:0] result_nxt;
   logic             busy_nxt;
   logic             load_n_nxt;
   logic             valid_nxt;
   logic             fault_nxt;

   logic [NBITS-1:0] trial;
   int unsigned      idx;
   logic             idx_bad;

   assign cnt_from = LAST_IDX;

   // Trial code for this cycle: bit idx takes the comparator decision,
   // the next lower bit is set for the following trial. The lower-bit
   // test is written as k+1 == idx so idx-1 is never formed at idx 0.
   always_comb begin
      idx     = 32'(cnt_val);
      idx_bad = (idx > NBITS - 1);
      trial   = dac_code;
      for (int k = 0; k < NBITS; k++) begin
         if (k == idx) begin
            trial[k] = cmp_in;
         end else if (k + 1 == idx) begin
            trial[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      dac_nxt    = dac_code;
      result_nxt = result;
      busy_nxt   = busy;
      load_n_nxt = cnt_load_n;
      valid_nxt  = result_valid;
      fault_nxt  = fault;

      unique case (state)
         S_IDLE: begin
            load_n_nxt = 1'b0;
            if (start && !abort) begin
               state_nxt  = S_CONVERT;
               dac_nxt    = MSB_CODE;
               load_n_nxt = 1'b1;
               busy_nxt   = 1'b1;
               fault_nxt  = 1'b0;
            end
         end

         S_CONVERT: begin
            // An impossible index is handled exactly like an abort,
            // and either one wins over completing on index 0.
            if (abort || idx_bad) begin
               state_nxt  = S_IDLE;
               dac_nxt    = '0;
               busy_nxt   = 1'b0;
               load_n_nxt = 1'b0;
               if (idx_bad) begin
                  fault_nxt = 1'b1;
               end
            end else if (idx == 0) begin
               state_nxt  = S_DONE;
               dac_nxt    = trial;
               result_nxt = trial;
               valid_nxt  = 1'b1;
               busy_nxt   = 1'b0;
               load_n_nxt = 1'b0;
            end else begin
               dac_nxt = trial;
            end
         end

         S_DONE: begin
            if (result_valid && result_ready) begin
               state_nxt = S_IDLE;
               valid_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt  = S_IDLE;
            dac_nxt    = '0;
            busy_nxt   = 1'b0;
            load_n_nxt = 1'b0;
            valid_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         dac_code     <= '0;
         result       <= '0;
         busy         <= 1'b0;
         cnt_load_n   <= 1'b0;
         result_valid <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= state_nxt;
         dac_code     <= dac_nxt;
         result       <= result_nxt;
         busy         <= busy_nxt;
         cnt_load_n   <= load_n_nxt;
         result_valid <= valid_nxt;
         fault        <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_sar_bit_sequencer.sv
// Directed bench for sar_bit_sequencer: 8-bit build with a down-counter
// and ideal comparator model, plus a 6-bit build for index faults.
module tb_sar_bit_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       result_ready;
   logic [7:0] vin;
   logic       cmp_in;
   logic [2:0] cnt_q;
   logic [2:0] cnt_val;
   logic       ovr;
   logic [2:0] ovr_val;
   logic       cnt_load_n;
   logic [2:0] cnt_from;
   logic [7:0] dac_code;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;
   logic       fault;

   logic       start6;
   logic       abort6;
   logic [2:0] cnt_val6;
   logic       cnt_load_n6;
   logic [2:0] cnt_from6;
   logic [5:0] dac_code6;
   logic       busy6;
   logic [5:0] result6;
   logic       result_valid6;
   logic       fault6;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sar_bit_sequencer #(.NBITS(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .cmp_in       (cmp_in),
      .cnt_val      (cnt_val),
      .cnt_load_n   (cnt_load_n),
      .cnt_from     (cnt_from),
      .dac_code     (dac_code),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .fault        (fault)
   );

   sar_bit_sequencer #(.NBITS(6)) dut6 (
      .clk          (clk),
      .reset        (reset),
      .start        (start6),
      .abort        (abort6),
      .cmp_in       (1'b0),
      .cnt_val      (cnt_val6),
      .cnt_load_n   (cnt_load_n6),
      .cnt_from     (cnt_from6),
      .dac_code     (dac_code6),
      .busy         (busy6),
      .result       (result6),
      .result_valid (result_valid6),
      .result_ready (1'b1),
      .fault        (fault6)
   );

   // Down-counter: load-low, decrement each clock, hold at zero.
   always_ff @(posedge clk) begin
      if (!cnt_load_n) begin
         cnt_q <= cnt_from;
      end else if (cnt_q != 3'd0) begin
         cnt_q <= cnt_q - 3'd1;
      end
   end

   assign cnt_val = ovr ? ovr_val : cnt_q;
   assign cmp_in  = (vin >= dac_code);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] v);
      vin   = v;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Run from the start edge to result_valid; report busy cycles seen.
   task automatic run_conv(input logic [7:0] v, output int nbusy,
                           output int ncyc);
      do_start(v);
      nbusy = 0;
      ncyc  = 0;
      while (!result_valid && ncyc < 20) begin
         if (busy) nbusy++;
         tick();
         ncyc++;
      end
   endtask

   task automatic accept();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic wait_cnt(input logic [2:0] v);
      int n = 0;
      while (cnt_q != v && n < 20) begin
         tick();
         n++;
      end
      chk("wait_cnt", 32'(n < 20), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_dac"}, 32'(dac_code), 32'h00);
      chk({tag, "_load_n"}, 32'(cnt_load_n), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'h00);
      chk({tag, "_valid"}, 32'(result_valid), 32'd0);
      chk({tag, "_fault"}, 32'(fault), 32'd0);
   endtask

   initial begin
      logic [7:0] seq_a5 [8];
      int nb;
      int nc;
      seq_a5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0,
                 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      cnt_q        = 3'd7;
      reset        = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      result_ready = 1'b0;
      vin          = 8'h00;
      ovr          = 1'b0;
      ovr_val      = 3'd0;
      start6       = 1'b0;
      abort6       = 1'b0;
      cnt_val6     = 3'd7;
      tick();
      tick();
      reset = 1'b0;
      tick();

      chk_reset_vals("rst");
      chk("cnt_from", 32'(cnt_from), 32'd7);
      chk("cnt_from6", 32'(cnt_from6), 32'd5);

      // Vin = 0xA5: full trial-code walk.
      do_start(8'hA5);
      chk("a5_busy", 32'(busy), 32'd1);
      chk("a5_load_n", 32'(cnt_load_n), 32'd1);
      chk("a5_d0", 32'(dac_code), 32'(seq_a5[0]));
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("a5_d%0d", k), 32'(dac_code), 32'(seq_a5[k]));
      end
      chk("a5_early", 32'(result_valid), 32'd0);
      tick();
      chk("a5_valid", 32'(result_valid), 32'd1);
      chk("a5_result", 32'(result), 32'hA5);
      chk("a5_busy_end", 32'(busy), 32'd0);
      chk("a5_load_end", 32'(cnt_load_n), 32'd0);
      accept();
      chk("a5_acc", 32'(result_valid), 32'd0);

      // Extremes.
      run_conv(8'h00, nb, nc);
      chk("z_valid", 32'(result_valid), 32'd1);
      chk("z_result", 32'(result), 32'h00);
      chk("z_busy_cyc", 32'(nb), 32'd8);
      chk("z_lat", 32'(nc), 32'd8);
      accept();
      run_conv(8'hFF, nb, nc);
      chk("f_valid", 32'(result_valid), 32'd1);
      chk("f_result", 32'(result), 32'hFF);
      chk("f_busy_cyc", 32'(nb), 32'd8);
      accept();

      // Backpressure, start in DONE is dropped.
      run_conv(8'h3C, nb, nc);
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         vin   = 8'h11;
         chk($sformatf("bp_valid%0d", k), 32'(result_valid), 32'd1);
         chk($sformatf("bp_res%0d", k), 32'(result), 32'h3C);
         tick();
      end
      start = 1'b0;
      accept();
      chk("bp_acc", 32'(result_valid), 32'd0);
      tick();
      chk("bp_noq", 32'(busy), 32'd0);
      chk("bp_noq_v", 32'(result_valid), 32'd0);

      // Abort at index 3, then a clean conversion.
      do_start(8'h77);
      wait_cnt(3'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_dac", 32'(dac_code), 32'h00);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_load_n", 32'(cnt_load_n), 32'd0);
      for (int k = 0; k < 10; k++) begin
         if (result_valid) break;
         tick();
      end
      chk("ab_nores", 32'(result_valid), 32'd0);
      run_conv(8'h5A, nb, nc);
      chk("ab_5a", 32'(result), 32'h5A);
      chk("ab_5a_v", 32'(result_valid), 32'd1);
      accept();

      // start together with abort in IDLE stays idle.
      vin   = 8'h42;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 32'(busy), 32'd0);

      // Reset mid-conversion.
      do_start(8'h99);
      wait_cnt(3'd4);
      reset = 1'b1;
      tick();
      chk_reset_vals("mr");
      reset = 1'b0;
      tick();

      // Counter stuck at 7: conversion never completes.
      ovr     = 1'b1;
      ovr_val = 3'd7;
      do_start(8'h12);
      for (int k = 0; k < 12; k++) tick();
      chk("stk_valid", 32'(result_valid), 32'd0);
      chk("stk_busy", 32'(busy), 32'd1);
      chk("stk_fault", 32'(fault), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      ovr   = 1'b0;
      chk("stk_abort", 32'(busy), 32'd0);

      // 6-bit build: index 7 is out of range.
      cnt_val6 = 3'd7;
      start6   = 1'b1;
      tick();
      start6 = 1'b0;
      chk("f6_busy", 32'(busy6), 32'd1);
      chk("f6_dac0", 32'(dac_code6), 32'h20);
      tick();
      chk("f6_fault", 32'(fault6), 32'd1);
      chk("f6_idle", 32'(busy6), 32'd0);
      chk("f6_dac", 32'(dac_code6), 32'h00);
      tick();
      tick();
      chk("f6_sticky", 32'(fault6), 32'd1);
      chk("f6_nores", 32'(result_valid6), 32'd0);
      cnt_val6 = 3'd5;
      start6   = 1'b1;
      tick();
      start6 = 1'b0;
      chk("f6_clr", 32'(fault6), 32'd0);
      chk("f6_busy2", 32'(busy6), 32'd1);
      abort6 = 1'b1;
      tick();
      abort6 = 1'b0;
      chk("f6_ab", 32'(busy6), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
